dnn_seq_ctrl: RTL and testbench

Sequencer and configuration controller for the 4-4-2 MLP datapath `dnn_top`, which has 5-bit signed weights and inputs, a 3-stage pipeline, and no backpressure.
- Holds the 24-entry weight bank, loaded serially over a config stream.
- Accepts input vectors over valid/ready and issues them to the datapath as `in_ready` pulses.
- Buffers results in a small FIFO toward a valid/ready consumer.
- Uses credit-based issue so results are never dropped.

---
 rtl/dnn_pkg.sv | 51 +++++
 rtl/dnn_res_fifo.sv | 64 ++++++
 rtl/dnn_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dnn_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// dnn_pkg: shared constants and types for the 4-4-2 MLP sequencer.
//   W_W/X_W   : weight / input element width (signed)
//   OUT_W     : datapath result width
//   N_W/N_L1  : total weights / layer-1 weights
//   DNN_LAT   : datapath latency, dnn_in_ready -> dnn_out_valid
//   state_e   : controller states
//   IDX_*     : bank index of each weight (wIJ = source node I -> dest node J)
package dnn_pkg;

    localparam int unsigned W_W     = 5;
    localparam int unsigned X_W     = 5;
    localparam int unsigned OUT_W   = 17;
    localparam int unsigned N_W     = 24;
    localparam int unsigned N_L1    = 16;
    localparam int unsigned DNN_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } state_e;

    // Layer 1: index = 4*input + hidden
    localparam int unsigned IDX_W04 = 0;
    localparam int unsigned IDX_W05 = 1;
    localparam int unsigned IDX_W06 = 2;
    localparam int unsigned IDX_W07 = 3;
    localparam int unsigned IDX_W14 = 4;
    localparam int unsigned IDX_W15 = 5;
    localparam int unsigned IDX_W16 = 6;
    localparam int unsigned IDX_W17 = 7;
    localparam int unsigned IDX_W24 = 8;
    localparam int unsigned IDX_W25 = 9;
    localparam int unsigned IDX_W26 = 10;
    localparam int unsigned IDX_W27 = 11;
    localparam int unsigned IDX_W34 = 12;
    localparam int unsigned IDX_W35 = 13;
    localparam int unsigned IDX_W36 = 14;
    localparam int unsigned IDX_W37 = 15;
    // Layer 2: index = N_L1 + 2*hidden + output
    localparam int unsigned IDX_W48 = 16;
    localparam int unsigned IDX_W49 = 17;
    localparam int unsigned IDX_W58 = 18;
    localparam int unsigned IDX_W59 = 19;
    localparam int unsigned IDX_W68 = 20;
    localparam int unsigned IDX_W69 = 21;
    localparam int unsigned IDX_W78 = 22;
    localparam int unsigned IDX_W79 = 23;

endpackage

// File: rtl/dnn_res_fifo.sv
// dnn_res_fifo: synchronous result FIFO.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/wdata_i: write request and data (ignored when full unless popping)
//   pop_i/rdata_o : read request and head-of-queue data
//   full_o/empty_o/count_o : occupancy status
module dnn_res_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot at the same edge, so a full FIFO may still accept.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/dnn_seq_ctrl.sv
// dnn_seq_ctrl: sequencer / configuration controller for the dnn_top MLP.
//   cfg_start/cfg_valid/cfg_data/cfg_ready : serial weight-bank load
//   x_valid/x_data/x_ready                 : input vector stream
//   dnn_x/dnn_w/dnn_in_ready               : issue side toward the datapath
//   dnn_out0/dnn_out1/dnn_out_valid        : datapath results
//   res_valid/res_data/res_ready           : buffered result stream
//   weights_loaded                         : bank complete and valid
//   err                                    : sticky [0] overflow, [1] unexpected result
module dnn_seq_ctrl
    import dnn_pkg::*;
#(
    parameter int unsigned RES_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic [W_W-1:0]         cfg_data,
    output logic                   cfg_ready,
    input  logic                   x_valid,
    input  logic [4*X_W-1:0]       x_data,
    output logic                   x_ready,
    output logic [4*X_W-1:0]       dnn_x,
    output logic [N_W*W_W-1:0]     dnn_w,
    output logic                   dnn_in_ready,
    input  logic [OUT_W-1:0]       dnn_out0,
    input  logic [OUT_W-1:0]       dnn_out1,
    input  logic                   dnn_out_valid,
    output logic                   res_valid,
    output logic [2*OUT_W-1:0]     res_data,
    input  logic                   res_ready,
    output logic                   weights_loaded,
    output logic [1:0]             err
);

    localparam int unsigned CW    = $clog2(RES_DEPTH) + 1;
    localparam int unsigned SUM_W = CW + 1;

    state_e                    state_q, state_d;
    logic [4:0]                idx_q, idx_d;
    logic [N_W-1:0][W_W-1:0]   bank_q, bank_d;
    logic                      wl_q, wl_d;
    logic [CW-1:0]             inflight_q, inflight_d;
    logic [4*X_W-1:0]          dnn_x_q, dnn_x_d;
    logic                      in_ready_q;
    logic [1:0]                err_q, err_d;

    logic [CW-1:0]             fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [SUM_W-1:0]          credit_used;
    logic                      issue;
    logic                      ret;
    logic                      stale;
    logic                      pop;
    logic                      overflow;

    // Credit: every in-flight vector owns a FIFO slot, so results are never dropped.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign x_ready     = (state_q == RUN) && (credit_used < SUM_W'(RES_DEPTH));
    assign cfg_ready   = (state_q == LOAD);

    assign issue    = x_valid && x_ready;
    assign ret      = dnn_out_valid && (inflight_q != '0);
    assign stale    = dnn_out_valid && (inflight_q == '0);
    assign res_valid = !fifo_empty;
    assign pop      = res_valid && res_ready;
    assign overflow = ret && fifo_full && !pop;

    assign dnn_x          = dnn_x_q;
    assign dnn_w          = bank_q;
    assign dnn_in_ready   = in_ready_q;
    assign weights_loaded = wl_q;
    assign err            = err_q;

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !ret) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!issue && ret) begin
            inflight_d = inflight_q - CW'(1);
        end
        dnn_x_d = issue ? x_data : dnn_x_q;
        err_d   = err_q | {stale, overflow};
    end

    // Leaving RUN/IDLE uses the post-edge inflight count so a vector issued
    // on the same edge as cfg_start forces DRAIN instead of a bank rewrite.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bank_d  = bank_q;
        wl_d    = wl_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (inflight_d == '0) begin
                        state_d = LOAD;
                        idx_d   = '0;
                        wl_d    = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    wl_d    = 1'b0;
                end
            end
            LOAD: begin
                if (cfg_start) begin
                    idx_d = '0;
                end else if (cfg_valid) begin
                    bank_d[idx_q] = cfg_data;
                    if (idx_q == 5'(N_W - 1)) begin
                        state_d = RUN;
                        idx_d   = '0;
                        wl_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            RUN: begin
                if (cfg_start) begin
                    if (inflight_d == '0) begin
                        state_d = LOAD;
                        idx_d   = '0;
                        wl_d    = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            bank_q     <= '0;
            wl_q       <= 1'b0;
            inflight_q <= '0;
            dnn_x_q    <= '0;
            in_ready_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bank_q     <= bank_d;
            wl_q       <= wl_d;
            inflight_q <= inflight_d;
            dnn_x_q    <= dnn_x_d;
            in_ready_q <= issue;
            err_q      <= err_d;
        end
    end

    dnn_res_fifo #(
        .WIDTH (2 * OUT_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (ret),
        .wdata_i ({dnn_out1, dnn_out0}),
        .pop_i   (pop),
        .rdata_o (res_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Credit accounting makes a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !overflow);

endmodule

// File: tb/tb_dnn_seq_ctrl.sv
module tb_dnn_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_start = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [4:0]   cfg_data = '0;
    logic         cfg_ready;
    logic         x_valid = 1'b0;
    logic [19:0]  x_data = '0;
    logic         x_ready;
    logic [19:0]  dnn_x;
    logic [119:0] dnn_w;
    logic         dnn_in_ready;
    logic [16:0]  dnn_out0;
    logic [16:0]  dnn_out1;
    logic         dnn_out_valid;
    logic         res_valid;
    logic [33:0]  res_data;
    logic         res_ready = 1'b1;
    logic         weights_loaded;
    logic [1:0]   err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dnn_seq_ctrl #(.RES_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_valid      (cfg_valid),
        .cfg_data       (cfg_data),
        .cfg_ready      (cfg_ready),
        .x_valid        (x_valid),
        .x_data         (x_data),
        .x_ready        (x_ready),
        .dnn_x          (dnn_x),
        .dnn_w          (dnn_w),
        .dnn_in_ready   (dnn_in_ready),
        .dnn_out0       (dnn_out0),
        .dnn_out1       (dnn_out1),
        .dnn_out_valid  (dnn_out_valid),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_ready      (res_ready),
        .weights_loaded (weights_loaded),
        .err            (err)
    );

    // ---------------- datapath stand-in: 4-4-2 MLP, ReLU hidden, 3 stages, never reset
    function automatic int model_out(input logic [19:0] x, input logic [119:0] w, input int k);
        int h, acc, xi, wi;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            h = 0;
            for (int i = 0; i < 4; i++) begin
                xi = $signed(x[5*i +: 5]);
                wi = $signed(w[5*(i*4+j) +: 5]);
                h += xi * wi;
            end
            if (h < 0) h = 0;
            wi = $signed(w[5*(16 + j*2 + k) +: 5]);
            acc += h * wi;
        end
        return acc;
    endfunction

    logic [2:0]  pv = '0;
    logic [16:0] o0 [3];
    logic [16:0] o1 [3];

    always @(posedge clk) begin
        pv    <= {pv[1:0], dnn_in_ready};
        o0[0] <= 17'(model_out(dnn_x, dnn_w, 0));
        o1[0] <= 17'(model_out(dnn_x, dnn_w, 1));
        o0[1] <= o0[0];
        o1[1] <= o1[0];
        o0[2] <= o0[1];
        o1[2] <= o1[1];
    end

    assign dnn_out_valid = pv[2];
    assign dnn_out0      = o0[2];
    assign dnn_out1      = o1[2];

    // ---------------- helpers
    function automatic logic [19:0] pack_x(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    // Weight sets: 0 all ones; 1 L1=-1 L2=3; 2 L1 identity + mixed L2; other = junk 7
    function automatic int wgt(input int s, input int k);
        if (s == 0) return 1;
        if (s == 1) return (k < 16) ? -1 : 3;
        if (s == 2) begin
            if (k < 16) return ((k / 4) == (k % 4)) ? 1 : 0;
            case (k)
                16: return 1;   // w48
                18: return 2;   // w58
                21: return 3;   // w69
                23: return -1;  // w79
                default: return 0;
            endcase
        end
        return 7;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_set(input int s, input bit do_start);
        logic [119:0] ew;
        int t;
        if (do_start) begin
            @(negedge clk);
            cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
        end
        t = 0;
        while (!cfg_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cfg_ready_in_load", cfg_ready, 1);
        check("x_ready_in_load", x_ready, 0);
        for (int k = 0; k < 24; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = 5'(wgt(s, k));
            if (k == 23) check("wl_before_last_beat", weights_loaded, 0);
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check("wl_after_last_beat", weights_loaded, 1);
        check("cfg_ready_after_load", cfg_ready, 0);
        for (int k = 0; k < 24; k++) ew[5*k +: 5] = 5'(wgt(s, k));
        check("dnn_w_bank", dnn_w, ew);
    endtask

    task automatic run_vec(input logic [19:0] x, input int e0, input int e1, input string nm);
        int t, lat;
        t = 0;
        while (!x_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("x_ready_wait", x_ready, 1);
        x_valid = 1'b1;
        x_data  = x;
        @(negedge clk);
        x_valid = 1'b0;
        check("in_ready_pulse", dnn_in_ready, 1);
        check("dnn_x_reg", dnn_x, x);
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) check("in_ready_one_cycle", dnn_in_ready, 0);
        end
        check("latency", lat, 5);
        check(nm, res_data, {17'(e1), 17'(e0)});
        @(negedge clk);
    endtask

    typedef struct {
        int          s;
        logic [19:0] x;
        int          e0;
        int          e1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur_set, sent, got, c;
        bit hs;

        tbl[0]  = '{0, pack_x(1, 1, 1, 1),     16,  16};
        tbl[1]  = '{0, pack_x(1, 0, 0, 0),      4,   4};
        tbl[2]  = '{0, pack_x(-1, -1, -1, -1),  0,   0};
        tbl[3]  = '{0, pack_x(2, -1, 0, 3),    16,  16};
        tbl[4]  = '{0, pack_x(15, 15, 15, 15), 240, 240};
        tbl[5]  = '{1, pack_x(2, 2, 2, 2),      0,   0};
        tbl[6]  = '{1, pack_x(-2, -2, -2, -2), 96,  96};
        tbl[7]  = '{2, pack_x(2, 1, 3, 1),      4,   8};
        tbl[8]  = '{2, pack_x(0, 0, 0, 5),      0,  -5};
        tbl[9]  = '{2, pack_x(5, 0, 0, 0),      5,   0};
        tbl[10] = '{2, pack_x(-3, 0, 4, 0),     0,  12};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_x_ready", x_ready, 0);
        check("rst_in_ready", dnn_in_ready, 0);
        check("rst_dnn_x", dnn_x, 0);
        check("rst_dnn_w", dnn_w, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_wl", weights_loaded, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_x_ready", x_ready, 0);
        check("idle_cfg_ready", cfg_ready, 0);

        // table-driven vectors, loading each weight set as needed
        cur_set = -1;
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].s != cur_set) begin
                load_set(tbl[i].s, 1'b1);
                cur_set = tbl[i].s;
            end
            run_vec(tbl[i].x, tbl[i].e0, tbl[i].e1, "vec_result");
        end

        // backpressure: consumer stalled, 6 vectors offered
        load_set(0, 1'b1);
        res_ready = 1'b0;
        sent = 0; got = 0; hs = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (hs) sent++;
            x_valid = (sent < 6);
            x_data  = pack_x(sent + 1, 0, 0, 0);
            hs = x_valid && x_ready;
            @(negedge clk);
        end
        check("bp_accepted", sent, 4);
        check("bp_x_ready_low", x_ready, 0);
        check("bp_res_valid", res_valid, 1);
        res_ready = 1'b1;
        c = 0;
        while (got < 6 && c < 80) begin
            if (hs) sent++;
            x_valid = (sent < 6);
            x_data  = pack_x(sent + 1, 0, 0, 0);
            hs = x_valid && x_ready;
            if (res_valid && res_ready) begin
                check("bp_order", res_data, {17'(4*(got+1)), 17'(4*(got+1))});
                got++;
            end
            @(negedge clk);
            c++;
        end
        x_valid = 1'b0;
        check("bp_got", got, 6);
        check("bp_sent", sent, 6);
        check("bp_err", err, 0);

        // reload while 3 vectors are in flight
        for (int k = 0; k < 3; k++) begin
            check("drain_issue_ready", x_ready, 1);
            x_valid = 1'b1;
            x_data  = pack_x(1, 0, 0, 0);
            @(negedge clk);
        end
        x_valid   = 1'b0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        got = 0; c = 0;
        while (!cfg_ready && c < 40) begin
            check("drain_x_ready", x_ready, 0);
            if (res_valid) begin
                check("drain_old_weights", res_data, {17'd4, 17'd4});
                got++;
            end
            @(negedge clk);
            c++;
        end
        check("drain_results_before_load", got, 3);
        load_set(2, 1'b0);
        run_vec(pack_x(2, 1, 3, 1), 4, 8, "drain_new_weights");

        // cfg_start coinciding with the 10th beat
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = 5'd7;
            @(negedge clk);
        end
        cfg_valid = 1'b1;
        cfg_data  = 5'd7;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check("restart_beat9_discarded", dnn_w[45 +: 5], 5'(wgt(2, 9)));
        check("restart_beat8_written", dnn_w[40 +: 5], 5'd7);
        check("restart_wl", weights_loaded, 0);
        load_set(1, 1'b0);
        run_vec(pack_x(-2, -2, -2, -2), 96, 96, "restart_result");

        // reset while 2 vectors are in flight
        x_valid = 1'b1;
        x_data  = pack_x(1, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        x_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_cfg_ready", cfg_ready, 0);
        check("ar_x_ready", x_ready, 0);
        check("ar_in_ready", dnn_in_ready, 0);
        check("ar_dnn_x", dnn_x, 0);
        check("ar_dnn_w", dnn_w, 0);
        check("ar_res_valid", res_valid, 0);
        check("ar_wl", weights_loaded, 0);
        check("ar_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("stale_fifo_empty", res_valid, 0);
        end
        check("stale_err", err, 2'b10);
        check("stale_x_ready", x_ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
